// File: rtl/ahb_dma_master.sv
// ahb_dma_master: memory-to-memory copy engine with an AHB-Lite master port.
// A copy is split into chunks no longer than BUF_DEPTH words that never cross
// a 1 KB boundary on either side; each chunk is an INCR (or SINGLE) read
// burst into a local buffer, followed by a write burst of the same length.
// Ports:
//   HCLK, HRESET                  clock, synchronous active-high reset
//   start, src_addr, dst_addr,    copy command (sampled while idle)
//   len
//   busy, done, err               status: in progress, completion pulse,
//                                 last copy aborted by a bus error
//   HADDR, HTRANS, HBURST, HSIZE, AHB-Lite master address/control/data
//   HWRITE, HWDATA, HREADY,
//   HRDATA, HRESP
module ahb_dma_master #(
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam int unsigned IW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = IW + 1;

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;

    typedef enum logic [2:0] {IDLE, RD, WR, ERR_WAIT, DONE} state_t;

    state_t         state_q, state_n;
    logic [31:0]    src_q, src_n, dst_q, dst_n;
    logic [15:0]    rem_q, rem_n;
    logic [CW-1:0]  chunk_q, chunk_n;
    logic [CW-1:0]  acnt_q, acnt_n;     // address phases accepted in this burst
    logic [CW-1:0]  dcnt_q, dcnt_n;     // data phases completed in this burst
    logic           dph_q, dph_n;       // a data phase is in progress
    logic [31:0]    haddr_n, hwdata_n;
    logic [1:0]     htrans_n;
    logic [2:0]     hburst_n;
    logic           hwrite_n, busy_n, done_n, err_n;
    logic           buf_we;
    logic [31:0]    buf_mem [BUF_DEPTH];

    logic [31:0]    src_adv, dst_adv;
    logic [15:0]    rem_left;
    logic [CW-1:0]  chunk_start, chunk_next;

    // Chunk length: min(remaining, BUF_DEPTH, words to the next 1 KB boundary of src and dst).
    function automatic logic [CW-1:0] chunk_f(input logic [15:0] rem,
                                              input logic [7:0]  s_word,
                                              input logic [7:0]  d_word);
        logic [CW-1:0] c;
        logic [8:0]    s_room;
        logic [8:0]    d_room;
        s_room = 9'd256 - 9'(s_word);
        d_room = 9'd256 - 9'(d_word);
        if (32'(rem) >= BUF_DEPTH) c = CW'(BUF_DEPTH);
        else                       c = CW'(rem);
        if (s_room < 9'(c)) c = CW'(s_room);
        if (d_room < 9'(c)) c = CW'(d_room);
        return c;
    endfunction

    function automatic logic [2:0] burst_of(input logic [CW-1:0] c);
        return (c == CW'(1)) ? HB_SINGLE : HB_INCR;
    endfunction

    assign HSIZE = 3'b010;

    // Candidate values for the chunk after the current one.
    assign src_adv     = src_q + 32'({chunk_q, 2'b00});
    assign dst_adv     = dst_q + 32'({chunk_q, 2'b00});
    assign rem_left    = rem_q - 16'(chunk_q);
    assign chunk_next  = chunk_f(rem_left, src_adv[9:2], dst_adv[9:2]);
    assign chunk_start = chunk_f(len, src_addr[9:2], dst_addr[9:2]);

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state_q;
        src_n    = src_q;
        dst_n    = dst_q;
        rem_n    = rem_q;
        chunk_n  = chunk_q;
        acnt_n   = acnt_q;
        dcnt_n   = dcnt_q;
        dph_n    = dph_q;
        haddr_n  = HADDR;
        htrans_n = HTRANS;
        hburst_n = HBURST;
        hwrite_n = HWRITE;
        hwdata_n = HWDATA;
        err_n    = err;
        buf_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_n = 1'b0;
                    if (len == 16'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n  = RD;
                        src_n    = src_addr;
                        dst_n    = dst_addr;
                        rem_n    = len;
                        chunk_n  = chunk_start;
                        acnt_n   = '0;
                        dcnt_n   = '0;
                        dph_n    = 1'b0;
                        haddr_n  = src_addr;
                        htrans_n = HT_NONSEQ;
                        hburst_n = burst_of(chunk_start);
                        hwrite_n = 1'b0;
                    end
                end
            end
            RD, WR: begin
                if (dph_q && HRESP) begin
                    // First ERROR cycle: drop the pending address phase and stop issuing.
                    state_n  = ERR_WAIT;
                    htrans_n = HT_IDLE;
                    dph_n    = 1'b0;
                end else if (HREADY) begin
                    dph_n = (HTRANS != HT_IDLE);
                    if (HTRANS != HT_IDLE) begin
                        acnt_n = acnt_q + CW'(1);
                        if (state_q == WR) hwdata_n = buf_mem[acnt_q[IW-1:0]];
                        if (acnt_q + CW'(1) < chunk_q) begin
                            haddr_n  = HADDR + 32'd4;
                            htrans_n = HT_SEQ;
                        end else begin
                            htrans_n = HT_IDLE;
                        end
                    end
                    if (dph_q) begin
                        dcnt_n = dcnt_q + CW'(1);
                        buf_we = (state_q == RD);
                        if (dcnt_q == chunk_q - CW'(1)) begin
                            acnt_n = '0;
                            dcnt_n = '0;
                            if (state_q == RD) begin
                                state_n  = WR;
                                haddr_n  = dst_q;
                                htrans_n = HT_NONSEQ;
                                hwrite_n = 1'b1;
                            end else if (rem_left == 16'd0) begin
                                state_n = DONE;
                            end else begin
                                state_n  = RD;
                                src_n    = src_adv;
                                dst_n    = dst_adv;
                                rem_n    = rem_left;
                                chunk_n  = chunk_next;
                                haddr_n  = src_adv;
                                htrans_n = HT_NONSEQ;
                                hburst_n = burst_of(chunk_next);
                                hwrite_n = 1'b0;
                            end
                        end
                    end
                end
            end
            ERR_WAIT: begin
                if (HREADY) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            dph_q   <= 1'b0;
            HADDR   <= '0;
            HTRANS  <= HT_IDLE;
            HBURST  <= HB_SINGLE;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            rem_q   <= rem_n;
            chunk_q <= chunk_n;
            acnt_q  <= acnt_n;
            dcnt_q  <= dcnt_n;
            dph_q   <= dph_n;
            HADDR   <= haddr_n;
            HTRANS  <= htrans_n;
            HBURST  <= hburst_n;
            HWRITE  <= hwrite_n;
            HWDATA  <= hwdata_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    // Chunk buffer; contents are only meaningful after a successful read burst.
    always_ff @(posedge HCLK) begin
        if (buf_we) buf_mem[dcnt_q[IW-1:0]] <= HRDATA;
    end

endmodule

// File: tb/tb_ahb_dma_master.sv
// tb_ahb_dma_master: randomized and directed checks of ahb_dma_master against
// a transfer-level reference model (expected beat list and completion cycle).
module tb_ahb_dma_master;

    localparam int unsigned BUF_DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HREADY, HRESP;

    always #5 HCLK = ~HCLK;

    ahb_dma_master #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HRESP(HRESP)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    exp_cycles, exp_nwr;
    logic  exp_err;

    // Source memory contents seen by the slave.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Expected bus beats and zero-wait completion cycle of one copy.
    task automatic model_build(input logic [31:0] src, input logic [31:0] dst,
                               input int n, input int err_rd);
        int rem = n;
        logic [31:0] s = src;
        logic [31:0] d = dst;
        int rd_n = 0;
        bit stop = 0;
        beat_t b;
        exp_q.delete();
        exp_err = 1'b0;
        exp_cycles = 1;
        exp_nwr = 0;
        while (rem > 0 && !stop) begin
            int c = rem;
            int sroom = (1024 - int'(s % 1024)) / 4;
            int droom = (1024 - int'(d % 1024)) / 4;
            if (c > int'(BUF_DEPTH)) c = int'(BUF_DEPTH);
            if (c > sroom) c = sroom;
            if (c > droom) c = droom;
            for (int i = 0; i < c; i++) begin
                b.addr  = s + 32'(4 * i);
                b.wr    = 1'b0;
                b.trans = (i == 0) ? 2'd2 : 2'd3;
                b.burst = (c == 1) ? 3'd0 : 3'd1;
                b.data  = rd_val(b.addr);
                exp_q.push_back(b);
                rd_n++;
                if (rd_n == err_rd) begin
                    stop = 1;
                    exp_err = 1'b1;
                    break;
                end
            end
            if (!stop) begin
                for (int i = 0; i < c; i++) begin
                    b.addr  = d + 32'(4 * i);
                    b.wr    = 1'b1;
                    b.trans = (i == 0) ? 2'd2 : 2'd3;
                    b.burst = (c == 1) ? 3'd0 : 3'd1;
                    b.data  = rd_val(s + 32'(4 * i));
                    exp_q.push_back(b);
                    exp_nwr++;
                end
                exp_cycles += 2 * c + 2;
                rem -= c;
                s += 32'(4 * c);
                d += 32'(4 * c);
            end
        end
    endtask

    // Slave and monitor state.
    bit          pend_valid, pend_wr, pend_err;
    logic [31:0] pend_addr, pend_data;
    int          pend_stall, err_stage, acc_idx, rd_cnt, wr_acc, wr_done;
    int          stall_total, done_cnt, done_cyc, err_cyc, cyc;
    bit          chk_err_next;
    int          cfg_err_rd, cfg_stall_prob, cfg_force_rd, cfg_force_len;

    // One bus cycle: respond as a slave, check presented beats, then advance.
    task automatic step();
        logic was_rst;
        beat_t b;
        was_rst = HRESET;
        @(posedge HCLK);
        #1;
        cyc++;
        start  = 1'b0;
        HRESET = 1'b0;
        if (was_rst) begin
            pend_valid = 0;
            err_stage  = 0;
        end

        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = $urandom;
        if (pend_valid) begin
            if (pend_err) begin
                if (err_stage == 0) begin
                    HREADY = 1'b0; HRESP = 1'b1; err_stage = 1; err_cyc = cyc;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b1; err_stage = 2;
                end
            end else if (pend_stall > 0) begin
                HREADY = 1'b0;
                pend_stall--;
                stall_total++;
            end
            if (!pend_wr) HRDATA = rd_val(pend_addr);
        end

        if (chk_err_next) begin
            chk("idle_after_err", 32'(HTRANS), 32'd0);
            chk_err_next = 0;
        end
        if (HTRANS != 2'd0 && !(HREADY == 1'b0 && HRESP == 1'b1)) begin
            if (acc_idx < exp_q.size()) begin
                b = exp_q[acc_idx];
                chk("haddr",  HADDR, b.addr);
                chk("htrans", 32'(HTRANS), 32'(b.trans));
                chk("hburst", 32'(HBURST), 32'(b.burst));
                chk("hwrite", 32'(HWRITE), 32'(b.wr));
                chk("hsize",  32'(HSIZE), 32'd2);
            end else begin
                chk("extra_beat", 32'(HTRANS), 32'd0);
            end
        end
        if (pend_valid && pend_wr) chk("hwdata", HWDATA, pend_data);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("err_at_done", 32'(err), 32'(exp_err));
        end

        if (HREADY) begin
            if (pend_valid && pend_wr) wr_done++;
            pend_valid = 0;
            if (HTRANS != 2'd0) begin
                pend_valid = 1;
                pend_wr    = HWRITE;
                pend_addr  = HADDR;
                pend_data  = (acc_idx < exp_q.size()) ? exp_q[acc_idx].data : 32'd0;
                if (!HWRITE) rd_cnt++; else wr_acc++;
                pend_err   = !HWRITE && (rd_cnt == cfg_err_rd);
                if (!HWRITE && rd_cnt == cfg_force_rd) pend_stall = cfg_force_len;
                else if (int'($urandom_range(99)) < cfg_stall_prob) pend_stall = int'($urandom_range(1, 3));
                else pend_stall = 0;
                acc_idx++;
            end
        end
        if (err_stage == 1 && err_cyc == cyc) chk_err_next = 1;
    endtask

    task automatic run(input logic [31:0] src, input logic [31:0] dst, input int n,
                       input int err_rd, input int stall_prob, input int force_rd,
                       input int force_len, input int rst_wr, input bit poke);
        int budget = n * 12 + 100;
        bit aborted = 0;
        int exp_done;
        model_build(src, dst, n, err_rd);
        acc_idx = 0; rd_cnt = 0; wr_acc = 0; wr_done = 0; stall_total = 0;
        done_cnt = 0; done_cyc = -1; err_cyc = -1; err_stage = 0;
        pend_valid = 0; chk_err_next = 0;
        cfg_err_rd = err_rd; cfg_stall_prob = stall_prob;
        cfg_force_rd = force_rd; cfg_force_len = force_len;

        step();
        cyc = 0;
        chk("busy_idle", 32'(busy), 32'd0);
        start = 1'b1; src_addr = src; dst_addr = dst; len = 16'(n);

        for (int k = 0; k < budget && done_cnt == 0 && !aborted; k++) begin
            step();
            chk("busy", 32'(busy), 32'd1);
            if (poke && cyc == 3) begin
                start = 1'b1; src_addr = $urandom; dst_addr = $urandom;
                len = 16'($urandom_range(1, 50));
            end
            if (rst_wr > 0 && wr_acc == rst_wr) begin
                HRESET = 1'b1;
                step();
                chk("rst_htrans", 32'(HTRANS), 32'd0);
                chk("rst_haddr",  HADDR, 32'd0);
                chk("rst_hburst", 32'(HBURST), 32'd0);
                chk("rst_hwrite", 32'(HWRITE), 32'd0);
                chk("rst_hwdata", HWDATA, 32'd0);
                chk("rst_busy",   32'(busy), 32'd0);
                chk("rst_done",   32'(done), 32'd0);
                aborted = 1;
            end
        end
        if (!aborted) begin
            exp_done = exp_err ? err_cyc + 2 : exp_cycles + stall_total;
            chk("done_seen",  32'(done_cnt), 32'd1);
            chk("done_cycle", 32'(done_cyc), 32'(exp_done));
            chk("beats",      32'(acc_idx), 32'(exp_q.size()));
            chk("writes",     32'(wr_done), 32'(exp_nwr));
            step();
            chk("busy_after", 32'(busy), 32'd0);
            chk("done_pulse", 32'(done), 32'd0);
            chk("err_hold",   32'(err), 32'(exp_err));
        end
    endtask

    initial begin
        HRESET = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; cyc = 0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_htrans", 32'(HTRANS), 32'd0);
        chk("reset_haddr",  HADDR, 32'd0);
        chk("reset_hburst", 32'(HBURST), 32'd0);
        chk("reset_hwrite", 32'(HWRITE), 32'd0);
        chk("reset_hwdata", HWDATA, 32'd0);
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_done",   32'(done), 32'd0);
        chk("reset_err",    32'(err), 32'd0);

        // Directed cases: len=4, len=1, boundary split, read stall, error, reset, len=0.
        run(32'h100, 32'h200, 4, 0, 0, 0, 0, 0, 0);
        run(32'h100, 32'h200, 1, 0, 0, 0, 0, 0, 0);
        run(32'h3F8, 32'h2000, 20, 0, 0, 0, 0, 0, 0);
        run(32'h100, 32'h200, 4, 0, 0, 2, 3, 0, 0);
        run(32'h100, 32'h200, 8, 3, 0, 0, 0, 0, 0);
        run(32'h100, 32'h200, 8, 0, 0, 0, 0, 2, 0);
        run(32'h100, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        run(32'hFFFF_FFF8, 32'h3F8, 6, 0, 0, 0, 0, 0, 1);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] s, d;
            int n, e;
            s = 32'($urandom_range(0, 32'h3FFF)) << 2;
            d = 32'h0010_0000 + (32'($urandom_range(0, 32'h3FFF)) << 2);
            n = int'($urandom_range(1, 40));
            e = ($urandom_range(3) == 0) ? int'($urandom_range(1, n)) : 0;
            run(s, d, n, e, 30, 0, 0, 0, bit'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_dma_master.md
AHB_DMA_MASTER -- requirements
Module: ahb_dma_master

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 8, meaning the internal word buffer depth and the maximum beats per burst (power of 2, 2..16).
REQ-002 SHALL have exactly one clock and a synchronous, active-high reset, listed first:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  synchronous active-high reset.
REQ-003 SHALL have the following command ports:
- start  in  1  one-cycle request to launch a copy.
- src_addr  in  32  word-aligned source address, sampled with start.
- dst_addr  in  32  word-aligned destination address, sampled with start.
- len  in  16  number of 32-bit words to copy, sampled with start.
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last copy aborted by a bus error; held until next start.
REQ-004 SHALL have the following AHB-Lite master ports:
- HADDR  out  32  transfer address.
- HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3; BUSY=1 is never driven.
- HBURST  out  3  SINGLE=0, INCR=1.
- HSIZE  out  3  constant 3'b010 (word).
- HWRITE  out  1  1 for write transfers.
- HWDATA  out  32  write data.
- HREADY  in  1  slave ready.
- HRDATA  in  32  read data.
- HRESP  in  1  OKAY=0, ERROR=1.

Function
REQ-005 SHALL implement states IDLE, RD, WR, ERR_WAIT and DONE.
REQ-006 In IDLE, start=1 with len!=0 SHALL latch src_addr/dst_addr/len and enter RD; start=1 with len=0 SHALL enter DONE with no bus transfer.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 Copies SHALL proceed in chunks of C = min(remaining, BUF_DEPTH, words left before the next 1 KB boundary of the current source or destination address).
REQ-009 A chunk SHALL be issued as a read burst (RD) followed by a write burst (WR) of the same C.
REQ-010 Each burst SHALL drive HBURST=SINGLE if C=1, else INCR.
REQ-011 Each burst's first beat SHALL be NONSEQ, following beats SEQ, and HADDR SHALL increment by 4 per beat.
REQ-012 Address and data phases SHALL be pipelined: the address of beat k+1 is driven in the same cycle as the data phase of beat k.
REQ-013 While HREADY=0, HADDR, HTRANS, HBURST, HWRITE and HWDATA SHALL be held stable.
REQ-014 Read data SHALL be captured into the buffer only in a read data-phase cycle with HREADY=1 and HRESP=OKAY.
REQ-015 HWDATA for beat k SHALL be driven from buffer[k] during that beat's data phase.
REQ-016 In the last data-phase cycle of a burst, HTRANS SHALL be IDLE.
REQ-017 After the last read beat's data phase completes, HTRANS SHALL be NONSEQ for the write burst in the next cycle.
REQ-018 After a write burst completes, if words remain the block SHALL return to RD with both addresses advanced by 4*C; otherwise it SHALL enter DONE.
REQ-019 On HRESP=ERROR (first cycle, HREADY=0), the next cycle SHALL drive HTRANS=IDLE and the state SHALL move to ERR_WAIT.
REQ-020 ERR_WAIT SHALL remain until HREADY=1, then enter DONE with err=1.
REQ-021 No further beats SHALL be issued after an ERROR, and no data SHALL be written from a chunk whose read failed.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in RD, WR, ERR_WAIT and DONE, and 0 in IDLE.
REQ-024 Timing with zero wait states, start in cycle 0, len=4:
- cycles 1-4: read addresses.
- cycle 5: last read data.
- cycles 6-9: write addresses.
- cycle 10: last write data.
- cycle 11: done=1.
REQ-025 The remaining-word counter SHALL be 16 bits, and address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-026 HRESET=1 SHALL, at the next edge and from any state (including mid-burst), force IDLE with:
- HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HWRITE=0, HWDATA=0.
- busy=0, done=0, err=0.
- counters cleared.
REQ-027 Buffer contents SHALL NOT require reset.

Verification
REQ-028 The bench SHALL cover: len=4, src=0x100, dst=0x200, HREADY=1 -> INCR reads 0x100..0x10C, then writes 0x200..0x20C with matching data; done in cycle 11.
REQ-029 The bench SHALL cover: len=1 -> one SINGLE NONSEQ read, then one SINGLE write; done in cycle 5.
REQ-030 The bench SHALL cover: len=20, BUF_DEPTH=8, src=0x3F8 -> chunks 2 (1 KB boundary), 8, 8, 2; all data correct.
REQ-031 The bench SHALL cover: HREADY=0 for 3 cycles on read beat 2 -> address and control held stable, data correct, completion delayed exactly 3 cycles.
REQ-032 The bench SHALL cover: ERROR on read beat 3 of len=8 -> HTRANS=IDLE next cycle, no writes issued, done=1 with err=1.
REQ-033 The bench SHALL cover: HRESET during WR beat 2 -> next cycle HTRANS=IDLE and busy=0; a subsequent start with len=0 -> done the next cycle, no bus activity.
